// File: rtl/mem_access_ctrl.sv
// -----------------------------------------------------------------------------
// mem_access_ctrl
//
// Memory-stage access controller. Turns the EX/MEM latch outputs into dcache
// requests, generates the shared pipeline-latch enable, and remembers a data
// access that finished while instruction fetch is still stalled, so that the
// access is not issued a second time. Halt is sticky until reset. A
// saturating counter records the cycles spent waiting on the dcache.
//
// Ports
//   CLK, nRST            clock (rising edge), asynchronous active-low reset
//   mem_dren/mem_dwen    load/store in MEM (both set -> store)
//   mem_addr/mem_wdata   byte address / store data from EX/MEM
//   mem_halt             halt instruction in MEM
//   ihit, dhit           icache hit / dcache access complete this cycle
//   dmemload             dcache read data, valid with dhit
//   dmemREN/dmemWEN      dcache read/write request
//   dmemaddr/dmemstore   dcache address / write data (passed through)
//   load_data            load result to the MEM/WB latch
//   pipe_en              enable for every pipeline latch
//   halt                 sticky halt to the caches
//   stall_cnt            saturating count of memory-stall cycles
//   dbg_state            current controller state (0 idle, 1 done, 2 halted)
//
// Handshake: a request (REN/WEN) is held constant with stable address/data
// until the cycle in which dhit is seen; the access completes in that cycle.
// -----------------------------------------------------------------------------
module mem_access_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             mem_dren,
  input  logic             mem_dwen,
  input  logic [31:0]      mem_addr,
  input  logic [31:0]      mem_wdata,
  input  logic             mem_halt,
  input  logic             ihit,
  input  logic             dhit,
  input  logic [31:0]      dmemload,
  output logic             dmemREN,
  output logic             dmemWEN,
  output logic [31:0]      dmemaddr,
  output logic [31:0]      dmemstore,
  output logic [31:0]      load_data,
  output logic             pipe_en,
  output logic             halt,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [1:0]       dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DONE   = 2'd1,
    S_HALTED = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [31:0]        ld_q, ld_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic               acc;
  logic               ren_raw, wen_raw, pipe_raw;

  assign acc = mem_dren | mem_dwen;

  always_comb begin
    state_d   = state_q;
    ld_d      = ld_q;
    cnt_d     = cnt_q;
    ren_raw   = 1'b0;
    wen_raw   = 1'b0;
    pipe_raw  = 1'b0;
    load_data = ld_q;

    unique case (state_q)
      S_IDLE: begin
        // A store wins when both enables are set.
        ren_raw  = mem_dren & ~mem_dwen;
        wen_raw  = mem_dwen;
        pipe_raw = ihit & (~acc | dhit);
        if (dhit) load_data = dmemload;
        if (dhit & mem_dren) ld_d = dmemload;
        // Access finished but fetch is not ready: park so it is not reissued.
        if (acc & dhit & ~ihit) state_d = S_DONE;
        // Outstanding miss: count it, saturating at all-ones.
        if (acc & ~dhit & (cnt_q != {CNT_W{1'b1}})) cnt_d = cnt_q + CNT_W'(1);
      end
      S_DONE: begin
        pipe_raw = ihit;
        if (ihit) state_d = S_IDLE;
      end
      S_HALTED: begin
        pipe_raw = 1'b0;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Halt takes effect only when the halt instruction actually advances.
    if (mem_halt & pipe_raw) state_d = S_HALTED;
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= S_IDLE;
      ld_q    <= 32'd0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ld_q    <= ld_d;
      cnt_q   <= cnt_d;
    end
  end

  // Requests and enable are forced low asynchronously while in reset.
  assign dmemREN   = nRST & ren_raw;
  assign dmemWEN   = nRST & wen_raw;
  assign pipe_en   = nRST & pipe_raw;
  assign dmemaddr  = mem_addr;
  assign dmemstore = mem_wdata;
  assign halt      = (state_q == S_HALTED);
  assign stall_cnt = cnt_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
module tb_mem_access_ctrl;

  logic        clk = 1'b0;
  logic        nrst;
  logic        mem_dren, mem_dwen, mem_halt, ihit, dhit;
  logic [31:0] mem_addr, mem_wdata, dmemload;
  logic        dmem_ren, dmem_wen, pipe_en, halt;
  logic [31:0] dmemaddr, dmemstore, load_data;
  logic [15:0] stall_cnt;
  logic [1:0]  dbg_state;

  int n_checks = 0;
  int n_errors = 0;

  mem_access_ctrl #(.CNT_W(16)) dut (
    .CLK(clk), .nRST(nrst),
    .mem_dren(mem_dren), .mem_dwen(mem_dwen), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_halt(mem_halt), .ihit(ihit), .dhit(dhit),
    .dmemload(dmemload), .dmemREN(dmem_ren), .dmemWEN(dmem_wen),
    .dmemaddr(dmemaddr), .dmemstore(dmemstore), .load_data(load_data),
    .pipe_en(pipe_en), .halt(halt), .stall_cnt(stall_cnt), .dbg_state(dbg_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  // m_waiting: the data access already completed, fetch not yet ready.
  bit          m_halted, m_waiting;
  logic [31:0] m_cap;
  int          m_cnt;
  logic        e_ren, e_wen, e_pipe;
  logic [31:0] e_load;

  task automatic model_reset();
    m_halted = 0; m_waiting = 0; m_cap = 32'd0; m_cnt = 0;
  endtask

  task automatic model_outputs();
    bit acc;
    acc = mem_dren | mem_dwen;
    e_ren = 0; e_wen = 0; e_pipe = 0; e_load = m_cap;
    if (nrst && !m_halted) begin
      if (m_waiting) e_pipe = ihit;
      else begin
        e_wen  = mem_dwen;
        e_ren  = mem_dren && !mem_dwen;
        e_pipe = ihit && (!acc || dhit);
        if (dhit) e_load = dmemload;
      end
    end else if (!m_halted && dhit) begin
      e_load = dmemload;
    end
  endtask

  task automatic model_edge();
    bit acc, idle;
    acc  = mem_dren | mem_dwen;
    idle = !m_halted && !m_waiting;
    model_outputs();
    if (!nrst) begin model_reset(); return; end
    if (idle && dhit && mem_dren) m_cap = dmemload;
    if (idle && acc && !dhit && m_cnt < 65535) m_cnt++;
    if (e_pipe && mem_halt) m_halted = 1;
    else if (idle && acc && dhit && !ihit) m_waiting = 1;
    else if (m_waiting && ihit) m_waiting = 0;
  endtask

  // ---------------- checking ----------------
  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic check_all();
    if (!nrst) model_reset();
    model_outputs();
    check("ren", 32'(dmem_ren), 32'(e_ren));
    check("wen", 32'(dmem_wen), 32'(e_wen));
    check("pipe_en", 32'(pipe_en), 32'(e_pipe));
    check("addr", dmemaddr, mem_addr);
    check("store", dmemstore, mem_wdata);
    check("load_data", load_data, e_load);
    check("halt", 32'(halt), 32'(m_halted));
    check("stall_cnt", 32'(stall_cnt), 32'(m_cnt));
  endtask

  // One cycle: compare at the falling edge, advance model at the rising edge.
  task automatic step(bit do_chk = 1);
    @(negedge clk);
    if (do_chk) check_all();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic set_in(bit dr, bit dw, bit hl, bit ih, bit dh,
                        logic [31:0] a, logic [31:0] wd, logic [31:0] ld);
    mem_dren = dr; mem_dwen = dw; mem_halt = hl; ihit = ih; dhit = dh;
    mem_addr = a; mem_wdata = wd; dmemload = ld;
  endtask

  task automatic do_reset();
    nrst = 0;
    step();
    step();
    nrst = 1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    model_reset();
    nrst = 0;
    // Requests and enable must be low in reset even with everything asserted.
    set_in(1, 1, 0, 1, 1, 32'h10, 32'h20, 32'h30);
    #2;
    check("rst_ren", 32'(dmem_ren), 32'd0);
    check("rst_wen", 32'(dmem_wen), 32'd0);
    check("rst_pipe", 32'(pipe_en), 32'd0);
    @(posedge clk); #1;
    step();
    nrst = 1;

    // Load hit with fetch ready.
    set_in(1, 0, 0, 1, 1, 32'h40, 32'h0, 32'hDEAD_BEEF);
    @(negedge clk);
    check("hit_ren", 32'(dmem_ren), 32'd1);
    check("hit_pipe", 32'(pipe_en), 32'd1);
    check("hit_load", load_data, 32'hDEAD_BEEF);
    @(posedge clk); model_edge(); #1;
    set_in(0, 0, 0, 1, 0, 32'h44, 32'h0, 32'h0);
    step();
    check("hit_cnt", 32'(stall_cnt), 32'd0);

    // Store miss for 3 cycles.
    for (int i = 0; i < 4; i++) begin
      set_in(0, 1, 0, 1, (i == 3), 32'h80, 32'h1234_5678, 32'h0);
      @(negedge clk);
      check("st_wen", 32'(dmem_wen), 32'd1);
      check("st_pipe", 32'(pipe_en), 32'(i == 3));
      @(posedge clk); model_edge(); #1;
    end
    check("st_cnt", 32'(stall_cnt), 32'd3);

    // dhit before ihit: access is remembered, not reissued.
    set_in(1, 0, 0, 0, 1, 32'h100, 32'h0, 32'hCAFE_0001);
    step();
    set_in(1, 0, 0, 0, 0, 32'h100, 32'h0, 32'h5555_5555);
    @(negedge clk);
    check("done_ren", 32'(dmem_ren), 32'd0);
    check("done_load", load_data, 32'hCAFE_0001);
    check("done_pipe", 32'(pipe_en), 32'd0);
    @(posedge clk); model_edge(); #1;
    ihit = 1;
    @(negedge clk);
    check("done_ren2", 32'(dmem_ren), 32'd0);
    check("done_pipe2", 32'(pipe_en), 32'd1);
    @(posedge clk); model_edge(); #1;

    // Halt is sticky and blocks later requests.
    set_in(0, 0, 1, 1, 0, 32'h0, 32'h0, 32'h0);
    step();
    set_in(1, 0, 0, 1, 1, 32'h200, 32'h0, 32'h1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("halt_on", 32'(halt), 32'd1);
      check("halt_ren", 32'(dmem_ren), 32'd0);
      check("halt_pipe", 32'(pipe_en), 32'd0);
      @(posedge clk); model_edge(); #1;
    end

    // Reset in the second cycle of a miss.
    do_reset();
    set_in(1, 0, 0, 1, 0, 32'h300, 32'h0, 32'h0);
    step();
    #2;
    check("mid_ren_pre", 32'(dmem_ren), 32'd1);
    nrst = 0;
    #1;
    check("mid_ren", 32'(dmem_ren), 32'd0);
    check("mid_pipe", 32'(pipe_en), 32'd0);
    step();
    nrst = 1;
    set_in(0, 0, 0, 1, 0, 32'h0, 32'h0, 32'h0);
    step();
    check("mid_cnt", 32'(stall_cnt), 32'd0);
    check("mid_halt", 32'(halt), 32'd0);

    // Saturation: long held miss, checked only around the wrap point.
    set_in(1, 0, 0, 1, 0, 32'h400, 32'h0, 32'h0);
    for (int i = 0; i < 65534; i++) step(0);
    check("sat_fffe", 32'(stall_cnt), 32'hFFFE);
    for (int i = 0; i < 5; i++) step();
    check("sat_ffff", 32'(stall_cnt), 32'hFFFF);

    // Randomized traffic against the model.
    do_reset();
    for (int i = 0; i < 2000; i++) begin
      nrst     = ($urandom_range(0, 79) != 0);
      mem_dren = ($urandom_range(0, 2) == 0);
      mem_dwen = ($urandom_range(0, 3) == 0);
      mem_halt = ($urandom_range(0, 49) == 0);
      ihit     = ($urandom_range(0, 2) != 0);
      dhit     = ($urandom_range(0, 1) == 0);
      mem_addr = $urandom; mem_wdata = $urandom; dmemload = $urandom;
      step();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mem_access_ctrl.md
# mem_access_ctrl

Memory-stage access controller for the pipelined core. It reads the EX/MEM latch outputs, issues the data-memory request to the dcache, and produces the common `pipe_en` that drives the `enable` input of every pipeline latch. It remembers a completed data access while instruction fetch is still stalled, so that the access is never reissued. It also makes halt sticky and keeps a saturating count of memory-stall cycles.

## Interface
Parameters:
- CNT_W, 16, width of stall-cycle counter

Ports:
- CLK  in  1  clock, rising edge
- nRST  in  1  asynchronous reset, active low
- mem_dren  in  1  DRen_o from EX/MEM latch (load in MEM)
- mem_dwen  in  1  DWen_o from EX/MEM latch (store in MEM)
- mem_addr  in  32  alu_out_o from EX/MEM (byte address)
- mem_wdata  in  32  rdat2_o from EX/MEM (store data)
- mem_halt  in  1  halt_o from EX/MEM
- ihit  in  1  icache hit this cycle
- dhit  in  1  dcache access complete this cycle
- dmemload  in  32  dcache read data, valid when dhit
- dmemREN  out  1  dcache read request
- dmemWEN  out  1  dcache write request
- dmemaddr  out  32  dcache address
- dmemstore  out  32  dcache write data
- load_data  out  32  load result to MEM/WB latch
- pipe_en  out  1  enable for all pipeline latches
- halt  out  1  sticky halt to caches
- stall_cnt  out  CNT_W  saturating count of memory-stall cycles

## Operation
- Clocking and reset: one clock; reset is asynchronous and active-low (CLK, nRST).
- Let acc = mem_dren | mem_dwen. If both are set, treat it as a store: WEN=1, REN=0.
- State machine:
  - IDLE
    - Requests are asserted combinationally: dmemREN=mem_dren&~mem_dwen, dmemWEN=mem_dwen, when acc & ~halt.
    - If acc & dhit & ~ihit, go to DONE.
    - Otherwise stay in IDLE.
  - DONE (data access finished, waiting for fetch)
    - dmemREN=dmemWEN=0.
    - load_data comes from the internal register captured at the dhit edge.
    - Return to IDLE on ihit.
  - HALTED
    - Entered from any state on the edge where mem_halt=1 and pipe_en would be 1.
    - Exit only by reset.
- dmemaddr=mem_addr and dmemstore=mem_wdata at all times; they are qualified only by REN/WEN.
- pipe_en:
  - IDLE: ihit & (~acc | dhit)
  - DONE: ihit
  - HALTED: 0
- load_data:
  - IDLE: dmemload when dhit, otherwise the captured register.
  - DONE: the register.
- Capture register: loads dmemload on every edge with state=IDLE & dhit & mem_dren.
- halt: 1 in HALTED, 0 otherwise.
- stall_cnt: +1 on every edge where state≠HALTED, ~pipe_en and an access is outstanding (IDLE&acc&~dhit). Saturates at all-ones and never wraps.
- Reset values:
  - state=IDLE, load register=0, stall_cnt=0, halt=0.
  - dmemREN=dmemWEN=0 while nRST=0, regardless of inputs.
  - pipe_en=0 while nRST=0.

## Timing
- Hit with fetch ready: acc, dhit and ihit all in cycle N give pipe_en=1 and load_data=dmemload in N. The MEM/WB latch captures at the end of N, and REN/WEN drop in N+1 because the next instruction is now in MEM.
- Miss: REN/WEN are held constant every cycle until dhit. Address and data must not change, since the EX/MEM latch is frozen by pipe_en=0.
- dhit before ihit: DONE is entered at edge N. From N+1 REN/WEN=0, load_data is held, and pipe_en=ihit.
- ihit alone with no access: pipe_en=ihit in the same cycle. This is zero-latency and combinational.
- dhit while ~acc (spurious): ignored, with no state change and no capture.
- Halt: mem_halt advancing at edge N gives halt=1 and pipe_en=0 from N+1 onward. A halt instruction carries no access.
- Reset asserted mid-miss: requests are forced to 0 immediately (asynchronously). After release, state is IDLE and the latch inputs come from their own reset values.

## Test plan
- Load to 0x0000_0040, dhit=1, ihit=1 in the same cycle → dmemREN=1, pipe_en=1 that cycle, load_data=dmemload=0xDEAD_BEEF, stall_cnt stays 0.
- Store 0x1234_5678 to 0x0000_0080, dhit delayed 3 cycles, ihit=1 throughout → dmemWEN=1 for 4 cycles with stable addr/data, pipe_en=1 only in the 4th, stall_cnt=3.
- Load with dhit in cycle 0 and ihit only in cycle 2 → dmemREN drops in cycle 1, load_data=captured value in cycles 1–2, pipe_en=1 only in cycle 2, with no second REN.
- Halt in MEM with ihit=1 → halt=1 the next cycle and remains 1, pipe_en=0 forever, and later mem_dren=1 produces no request.
- Starting with stall_cnt=0xFFFE, hold a miss for 5 cycles → count reads 0xFFFF and stays there.
- Drop nRST during the 2nd miss cycle → dmemREN=0 and pipe_en=0 immediately. After release, state is IDLE and stall_cnt=0.
